// File: rtl/gcd_traffic_engine.sv
// Traffic engine for a DecoupledGcd block: sweeps (x,y) requests over the request
// channel and checks every response in order by repeated subtraction.
module gcd_traffic_engine #(
  parameter int WIDTH     = 60,
  parameter int MIN_VAL   = 2,
  parameter int MAX_X     = 100,
  parameter int MAX_Y     = 100,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 enq_ready,
  output logic                 enq_valid,
  output logic [WIDTH-1:0]     enq_bits_value1,
  output logic [WIDTH-1:0]     enq_bits_value2,
  input  logic                 deq_valid,
  output logic                 deq_ready,
  input  logic [WIDTH-1:0]     deq_bits_value1,
  input  logic [WIDTH-1:0]     deq_bits_value2,
  input  logic [WIDTH-1:0]     deq_bits_gcd,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_WIDTH-1:0] req_count,
  output logic [CNT_WIDTH-1:0] resp_count,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam logic [1:0] GEN_IDLE  = 2'd0;
  localparam logic [1:0] GEN_SEND  = 2'd1;
  localparam logic [1:0] GEN_SENT  = 2'd2;

  localparam logic [1:0] CHK_IDLE  = 2'd0;
  localparam logic [1:0] CHK_WAIT  = 2'd1;
  localparam logic [1:0] CHK_CHECK = 2'd2;
  localparam logic [1:0] CHK_FIN   = 2'd3;

  localparam logic [WIDTH-1:0]     MIN_W   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0]     MAX_X_W = WIDTH'(MAX_X);
  localparam logic [WIDTH-1:0]     MAX_Y_W = WIDTH'(MAX_Y);
  localparam logic [WIDTH-1:0]     ONE_W   = WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [1:0]       gen_state;
  logic [1:0]       chk_state;
  logic [WIDTH-1:0] x, y;
  logic [WIDTH-1:0] ex, ey;
  logic [WIDTH-1:0] v1, v2, g;
  logic [WIDTH-1:0] r1, r2;

  logic start_ok;
  logic enq_fire;
  logic deq_fire;
  logic finish;
  logic last_req;
  logic last_resp;
  logic chk_exit;
  logic resp_err;

  assign enq_valid       = (gen_state == GEN_SEND);
  assign enq_bits_value1 = x;
  assign enq_bits_value2 = y;
  assign deq_ready       = (chk_state == CHK_WAIT) && (resp_count < req_count);

  assign start_ok  = start && !busy;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;
  assign finish    = (gen_state == GEN_SENT) && (chk_state == CHK_FIN);
  assign last_req  = (x == MAX_X_W) && (y == MAX_Y_W);
  assign last_resp = (ex == MAX_X_W) && (ey == MAX_Y_W);

  // A zero gcd can never be reduced, so it exits the check at once.
  assign chk_exit = (chk_state == CHK_CHECK) && ((g == '0) || ((r1 < g) && (r2 < g)));
  assign resp_err = (v1 != ex) || (v2 != ey) || (g == '0) || (r1 != '0) || (r2 != '0);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gen_state <= GEN_IDLE;
      x         <= '0;
      y         <= '0;
    end else if (start_ok) begin
      gen_state <= GEN_SEND;
      x         <= MIN_W;
      y         <= MIN_W;
    end else begin
      case (gen_state)
        GEN_SEND: begin
          if (enq_fire) begin
            if (last_req) gen_state <= GEN_SENT;
            if (y == MAX_Y_W) begin
              y <= MIN_W;
              x <= x + ONE_W;
            end else begin
              y <= y + ONE_W;
            end
          end
        end
        GEN_SENT: if (finish) gen_state <= GEN_IDLE;
        default:  gen_state <= gen_state;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chk_state <= CHK_IDLE;
      ex        <= '0;
      ey        <= '0;
      v1        <= '0;
      v2        <= '0;
      g         <= '0;
      r1        <= '0;
      r2        <= '0;
    end else if (start_ok) begin
      chk_state <= CHK_WAIT;
      ex        <= MIN_W;
      ey        <= MIN_W;
    end else begin
      case (chk_state)
        CHK_WAIT: begin
          if (deq_fire) begin
            v1        <= deq_bits_value1;
            v2        <= deq_bits_value2;
            g         <= deq_bits_gcd;
            r1        <= deq_bits_value1;
            r2        <= deq_bits_value2;
            chk_state <= CHK_CHECK;
          end
        end
        CHK_CHECK: begin
          if (chk_exit) begin
            chk_state <= last_resp ? CHK_FIN : CHK_WAIT;
            if (ey == MAX_Y_W) begin
              ey <= MIN_W;
              ex <= ex + ONE_W;
            end else begin
              ey <= ey + ONE_W;
            end
          end else begin
            // Both remainders shrink together; the >= guard keeps them from wrapping.
            if (r1 >= g) r1 <= r1 - g;
            if (r2 >= g) r2 <= r2 - g;
          end
        end
        CHK_FIN: if (finish) chk_state <= CHK_IDLE;
        default: chk_state <= chk_state;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      req_count   <= '0;
      resp_count  <= '0;
      error_count <= '0;
      cycle_count <= '0;
    end else if (start_ok) begin
      busy        <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      req_count   <= '0;
      resp_count  <= '0;
      error_count <= '0;
      cycle_count <= '0;
    end else begin
      if (enq_fire) req_count <= sat_inc(req_count);
      if (chk_exit) begin
        resp_count <= sat_inc(resp_count);
        if (resp_err) error_count <= sat_inc(error_count);
      end
      if (busy) begin
        if (finish) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (error_count == '0);
        end else begin
          cycle_count <= sat_inc(cycle_count);
        end
      end
    end
  end

endmodule
